// File: rtl/mdu_scheduler.sv
// mdu_scheduler: multiply/divide sequencer and HI/LO register owner.
//
// Accepts MD ops from EX, holds busy for MULT_CYCLES / DIV_CYCLES cycles,
// then commits the result to HI/LO. MTHI/MTLO write HI/LO at once. While
// the unit is busy, an MD instruction in ID raises a stall request.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      synchronous reset, active-low
//   start      EX holds a valid MD op this cycle
//   op[2:0]    0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=no-op
//   rs_val     forwarded rs operand
//   rt_val     forwarded rt operand
//   id_is_md   ID-stage instruction is an MD instruction
//   busy       multi-cycle op in progress
//   stall_req  ID stall request (combinational)
//   hi, lo     HI/LO registers
module mdu_scheduler #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        id_is_md,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          uns_q, uns_d;     // op[0] of the latched op: 1 = unsigned variant
    logic [31:0]   rs_q, rs_d;
    logic [31:0]   rt_q, rt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    // Result datapath, driven only by latched operands.
    logic [63:0] prod;
    logic [31:0] dvd_mag, dvs_mag, q_mag, r_mag, quo, rem;
    logic        sgn;

    always_comb begin
        sgn = ~uns_q;
        if (sgn) prod = {{32{rs_q[31]}}, rs_q} * {{32{rt_q[31]}}, rt_q};
        else     prod = {32'b0, rs_q} * {32'b0, rt_q};

        // Signed divide via magnitudes: 0x80000000 keeps its bit pattern as a
        // magnitude, so MIN/-1 yields quotient 0x80000000, remainder 0.
        dvd_mag = (sgn && rs_q[31]) ? (~rs_q + 32'd1) : rs_q;
        dvs_mag = (sgn && rt_q[31]) ? (~rt_q + 32'd1) : rt_q;
        if (dvs_mag == 32'd0) dvs_mag = 32'd1;   // result discarded on divide-by-zero
        q_mag = dvd_mag / dvs_mag;
        r_mag = dvd_mag % dvs_mag;
        quo   = (sgn && (rs_q[31] ^ rt_q[31])) ? (~q_mag + 32'd1) : q_mag;
        rem   = (sgn && rs_q[31]) ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        uns_d   = uns_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1: begin
                            uns_d   = op[0];
                            rs_d    = rs_val;
                            rt_d    = rt_val;
                            cnt_d   = MUL_LOAD;
                            state_d = MUL_RUN;
                        end
                        3'd2, 3'd3: begin
                            uns_d   = op[0];
                            rs_d    = rs_val;
                            rt_d    = rt_val;
                            cnt_d   = DIV_LOAD;
                            state_d = DIV_RUN;
                        end
                        3'd4:    hi_d = rs_val;
                        3'd5:    lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            MUL_RUN, DIV_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                    if (state_q == MUL_RUN) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (rt_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            uns_q   <= 1'b0;
            rs_q    <= '0;
            rt_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            uns_q   <= uns_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign stall_req = id_is_md & (start | busy);
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_scheduler.sv
// tb_mdu_scheduler: self-checking bench for mdu_scheduler.
// Table of MD ops with hand-computed HI/LO results plus directed sequences
// for stall, ignored start, MTHI/MTLO, divide-by-zero and mid-op reset.
module tb_mdu_scheduler;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        id_is_md;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mdu_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .id_is_md  (id_is_md),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one op for one cycle (start edge at T); returns at negedge T+1
    // with operands scrambled so results must come from the latched copies.
    task automatic drive_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        #1 check("busy_at_start", {31'b0, busy}, 32'd0);
        @(negedge clk);
        start  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    task automatic push_exp(input string n, input logic [31:0] h, input logic [31:0] l,
                            input int unsigned c);
        exp_t e;
        e.name = n;
        e.hi   = h;
        e.lo   = l;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Count remaining busy cycles (bounded), then pop and compare.
    task automatic wait_done();
        exp_t e;
        int unsigned n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check({e.name, "_busy_cycles"}, 32'(n), 32'(e.cyc));
            check({e.name, "_hi"}, hi, e.hi);
            check({e.name, "_lo"}, lo, e.lo);
        end
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, MC};
        vecs[1] = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MC};
        vecs[2] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       DC};
        vecs[3] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
        vecs[5] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, MC};
        vecs[6] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
        vecs[7] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
        vecs[8] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
        vecs[9] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, DC};

        reset = 1'b0; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0; id_is_md = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_stall", {31'b0, stall_req}, 32'd0);
        id_is_md = 1'b0;

        for (int i = 0; i < 10; i++) begin
            push_exp($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, vecs[i].cyc);
            drive_op(vecs[i].op, vecs[i].rs, vecs[i].rt);
            wait_done();
        end

        // Stall request while id_is_md is held high across a MULT.
        begin
            int unsigned n = 0;
            id_is_md = 1'b1;
            @(negedge clk);
            start = 1'b1; op = 3'd0; rs_val = 32'd3; rt_val = 32'd9;
            #1 check("stall_at_start", {31'b0, stall_req}, 32'd1);
            @(negedge clk);
            start = 1'b0;
            while (stall_req === 1'b1 && n < 64) begin
                n++;
                @(negedge clk);
            end
            check("stall_busy_cycles", 32'(n), 32'(MC));
            check("stall_after", {31'b0, stall_req}, 32'd0);
            check("stall_mult_lo", lo, 32'd27);
            id_is_md = 1'b0;
        end

        // No stall when the ID instruction is not an MD op.
        begin
            logic seen = 1'b0;
            @(negedge clk);
            start = 1'b1; op = 3'd0; rs_val = 32'd7; rt_val = 32'd6;
            #1 seen |= stall_req;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 8; i++) begin
                seen |= stall_req;
                @(negedge clk);
            end
            check("nostall_seen", {31'b0, seen}, 32'd0);
            check("nostall_lo", lo, 32'd42);
        end

        // Second start mid-MULT is ignored: busy runs out on the original count.
        push_exp("ignore_start", 32'd0, 32'd12, MC - 2);
        drive_op(3'd0, 32'd3, 32'd4);
        @(negedge clk);
        start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);
        check("ignore_start_idle", {31'b0, busy}, 32'd0);

        // MTHI/MTLO, then DIV by zero leaves them intact.
        drive_op(3'd4, 32'h11, 32'd0);
        check("mthi_busy", {31'b0, busy}, 32'd0);
        check("mthi_hi", hi, 32'h11);
        drive_op(3'd5, 32'h22, 32'd0);
        check("mtlo_lo", lo, 32'h22);
        check("mtlo_hi_kept", hi, 32'h11);
        push_exp("div0", 32'h11, 32'h22, DC);
        drive_op(3'd2, 32'd5, 32'd0);
        wait_done();

        // Reserved op is a no-op.
        drive_op(3'd6, 32'hDEAD, 32'hBEEF);
        check("noop_busy", {31'b0, busy}, 32'd0);
        check("noop_hi", hi, 32'h11);
        check("noop_lo", lo, 32'h22);

        // Reset pulse at T+3 of a DIV abandons it.
        begin
            logic seen = 1'b0;
            drive_op(3'd3, 32'd100, 32'd7);
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            check("rst_mid_busy", {31'b0, busy}, 32'd0);
            check("rst_mid_hi", hi, 32'd0);
            check("rst_mid_lo", lo, 32'd0);
            for (int i = 0; i < 15; i++) begin
                seen |= busy;
                @(negedge clk);
            end
            check("rst_mid_no_busy", {31'b0, seen}, 32'd0);
            check("rst_mid_no_commit_hi", hi, 32'd0);
            check("rst_mid_no_commit_lo", lo, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_scheduler.md
Name: mdu_scheduler

Overview:
- Sequences the multiply/divide unit and owns the HI/LO registers for the 5-stage pipeline.
- Accepts MD operations issued from EX and models the multi-cycle latency with a busy counter.
- Commits results to HI/LO when the operation completes.
- Generates the ID-stage stall request for any MD instruction that arrives while the unit is occupied.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous reset, active-low
start  input  1  EX holds a valid MD op this cycle
op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved (no-op)
rs_val  input  32  forwarded rs operand from EX
rt_val  input  32  forwarded rt operand from EX
id_is_md  input  1  instruction in ID is MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO
busy  output  1  multi-cycle op in progress
stall_req  output  1  ID stall request, combinational
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset: reset==0 at a rising edge forces state=IDLE, counter=0, hi=0, lo=0, busy=0, operand latches=0. This applies mid-operation: the in-flight op is abandoned and nothing is committed.
- States: IDLE, MUL_RUN, DIV_RUN. busy=1 exactly in MUL_RUN and DIV_RUN.
- IDLE with start=1 and op in 0..3:
  - Latch rs_val, rt_val and op.
  - Load counter with MULT_CYCLES-1 (ops 0,1) or DIV_CYCLES-1 (ops 2,3).
  - Go to MUL_RUN or DIV_RUN.
  - busy is high for exactly N consecutive cycles starting the cycle after start.
- RUN state, counter!=0: decrement counter.
- RUN state, counter==0:
  - Commit the result to hi/lo at this edge and return to IDLE.
  - New hi/lo are visible the cycle after the last busy cycle.
- IDLE with start=1 and op=4/5: hi<=rs_val (op 4) or lo<=rs_val (op 5) at that edge; busy stays 0.
- IDLE with start=1 and op=6/7: no state change.
- start=1 while busy: ignored entirely (the stall makes this illegal; the bench checks it is harmless).
- stall_req = id_is_md & (start | busy). While start=1 this covers only start with op 0..3 or 4/5 writes; for simplicity, any start counts.
- Arithmetic:
  - MULT: signed 32x32 -> 64; {hi,lo} <= product.
  - MULTU: same, unsigned.
  - DIV: signed; lo <= quotient truncated toward zero; hi <= remainder with the sign of the dividend (rs).
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU: unsigned quotient/remainder.
  - Divisor (latched rt)==0 for DIV/DIVU: full busy period still elapses; hi/lo unchanged at completion.
- Results are computed from the latched operands only; rs_val/rt_val changes during RUN have no effect.
- hi/lo are read combinationally by MFHI/MFLO. Because of the stall, a read never occurs while busy.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> busy high cycles T+1..T+5, low at T+6; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- DIVU rs=100, rt=7 -> busy 10 cycles, then lo=14, hi=2.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV by 0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> 10 busy cycles, then hi=0x11, lo=0x22.
- Stall and reset:
  - With id_is_md=1 held from T: stall_req=1 during T (start) and T+1..T+5 (MULT), stall_req=0 at T+6.
  - id_is_md=0 -> stall_req=0 throughout.
  - Second start during busy leaves the counter and result unaffected.
  - Pulsing reset=0 at T+3 of a DIV -> busy=0, hi=lo=0 next cycle, and no later commit.
